// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch-stage PC register, next-PC selection and IF/ID clear generation.
// Define BTB_PRED_EN to build the direct-mapped BTB predictor; without it fetch is strictly sequential.
module pc_fetch_unit #(
    parameter int ADDR_W    = 10,
    parameter int BTB_IDX_W = 4,
    parameter int RESET_PC  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              stall,
    input  logic              halt,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              upd_en,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_4,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    output logic              if_id_clr,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

    logic              run;
    logic [ADDR_W-1:0] pc_next;

    // A halted or disabled unit ignores redirects, updates and prediction alike.
    assign run       = en && !halted;
    assign pc_4      = pc + ONE;
    assign if_id_clr = !(run && redirect);

`ifdef BTB_PRED_EN
    localparam int TAG_W = ADDR_W - BTB_IDX_W;
    localparam int BTB_N = 1 << BTB_IDX_W;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        logic [1:0]        ctr;
    } btb_entry_t;

    btb_entry_t           btb [BTB_N];
    btb_entry_t           look_e;
    btb_entry_t           upd_e;
    btb_entry_t           upd_new;
    logic [BTB_IDX_W-1:0] look_idx;
    logic [BTB_IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0]     look_tag;
    logic [TAG_W-1:0]     upd_tag;
    logic                 look_hit;
    logic                 upd_hit;

    assign look_idx = pc[BTB_IDX_W-1:0];
    assign look_tag = pc[ADDR_W-1:BTB_IDX_W];
    assign upd_idx  = upd_pc[BTB_IDX_W-1:0];
    assign upd_tag  = upd_pc[ADDR_W-1:BTB_IDX_W];

    // Lookup reads the stored entry directly; a same-cycle update is not bypassed.
    assign look_e   = btb[look_idx];
    assign look_hit = look_e.valid && (look_e.tag == look_tag);
    assign upd_e    = btb[upd_idx];
    assign upd_hit  = upd_e.valid && (upd_e.tag == upd_tag);

    assign pred_taken  = look_hit && look_e.ctr[1];
    assign pred_target = look_hit ? look_e.target : '0;

    always_comb begin
        upd_new = upd_e;
        if (upd_hit) begin
            if (upd_taken) begin
                if (upd_e.ctr != 2'b11) upd_new.ctr = upd_e.ctr + 2'b01;
                upd_new.target = upd_target;
            end else if (upd_e.ctr != 2'b00) begin
                upd_new.ctr = upd_e.ctr - 2'b01;
            end
        end else if (upd_taken) begin
            upd_new.valid  = 1'b1;
            upd_new.tag    = upd_tag;
            upd_new.target = upd_target;
            upd_new.ctr    = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the BTB is flop-based and must be reset so stale entries never predict after rst_n.
            for (int i = 0; i < BTB_N; i++) begin
                btb[i].valid  <= 1'b0;
                btb[i].tag    <= '0;
                btb[i].target <= '0;
                btb[i].ctr    <= 2'b01;
            end
        end else if (run && upd_en) begin
            btb[upd_idx] <= upd_new;
        end
    end
`else
    logic unused_upd;

    assign pred_taken  = 1'b0;
    assign pred_target = '0;
    assign unused_upd  = ^{upd_en, upd_pc, upd_taken, upd_target};
`endif

    always_comb begin
        // NOTE: pc_next gets a default before the priority chain so no branch can infer a latch.
        pc_next = pc;
        if (!run) begin
            pc_next = pc;
        end else if (redirect) begin
            pc_next = redirect_pc;
        end else if (stall) begin
            pc_next = pc;
`ifdef BTB_PRED_EN
        end else if (pred_taken) begin
            pc_next = pred_target;
`endif
        end else begin
            pc_next = pc_4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            pc <= RESET_ADDR;
        end else begin
            pc <= pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else if (en && halt) begin
            halted <= 1'b1;
        end
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the PC register and produces the fetch address and pc_4 that the IF/ID register captures. A small direct-mapped BTB with 2-bit saturating counters predicts taken branches and jumps. It accepts stall, halt and EX-stage redirects, and drives the active-low clear of IF/ID on redirect.

Parameters:
ADDR_W, 10, word-address width of instruction memory (equals IM_ADDR_BIT)
BTB_IDX_W, 4, BTB index width; 2^BTB_IDX_W entries
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  global run enable; low freezes PC, BTB and halted
stall  in  1  hazard stall; hold PC
halt  in  1  halt request from WB (syscall)
redirect  in  1  EX-stage correction (mispredict or jump)
redirect_pc  in  ADDR_W  corrected fetch address
upd_en  in  1  BTB update strobe from EX (resolved branch)
upd_pc  in  ADDR_W  address of the resolved branch
upd_taken  in  1  resolved outcome
upd_target  in  ADDR_W  resolved target
pc  out  ADDR_W  current fetch address to instruction memory
pc_4  out  ADDR_W  pc+1 (word address), to IF/ID
pred_taken  out  1  prediction for the current pc, carried down the pipe
pred_target  out  ADDR_W  predicted target, carried down the pipe
if_id_clr  out  1  active-low clear for IF/ID
halted  out  1  sticky halt status

Behaviour:
- Reset (async, rst_n low): pc=RESET_PC, halted=0, all BTB valid=0, counters=2'b01, tags/targets=0.
- Reset consequences: pred_taken=0, pred_target=0, if_id_clr=1, pc_4=RESET_PC+1. Reset mid-operation discards all state immediately.
- BTB entry fields: valid, tag = pc[ADDR_W-1:BTB_IDX_W], target, ctr[1:0].
- Lookup is combinational on the registered pc, indexed by pc[BTB_IDX_W-1:0].
- hit = valid && tag match.
- pred_taken = hit && ctr[1].
- pred_target = entry target when hit, else 0.
- pc_4 = pc+1 modulo 2^ADDR_W (wraps 2^ADDR_W-1 -> 0).
- Next-PC priority, evaluated at each posedge:
  - (1) halted or !en -> hold.
  - (2) redirect -> redirect_pc; redirect overrides stall.
  - (3) stall -> hold.
  - (4) pred_taken -> pred_target.
  - (5) otherwise pc_4.
- if_id_clr = !(en && redirect && !halted), combinational. It is low only in the redirect cycle, so IF/ID drops the wrong-path fetch at the same edge the PC redirects.
- halted sets at the first posedge with en && halt, and stays set until reset. Once halted, PC and BTB are frozen and redirect/upd are ignored.
- BTB update at posedge when en && upd_en && !halted:
  - Index and tag are taken from upd_pc.
  - Hit + taken: ctr saturating-increments (max 2'b11); target <= upd_target.
  - Hit + not taken: ctr saturating-decrements (min 2'b00); target unchanged.
  - Miss + taken: allocate/replace: valid=1, tag, target, ctr=2'b10.
  - Miss + not taken: no change.
- Update and lookup to the same entry in the same cycle: the lookup uses the pre-update contents (no bypass); the update lands at the edge.
- Update and redirect in the same cycle are independent and both take effect.
- No handshake. The downstream IF/ID register applies its own en/stall. This block must be fed the same stall so that PC and IF/ID hold together.

Optional Feature:
BTB_PRED_EN
- Defined: BTB storage and prediction as described.
- Undefined:
  - No BTB storage is synthesised.
  - pred_taken=0 and pred_target=0 constantly.
  - Next-PC step (4) is removed.
  - upd_* inputs are ignored.
  - All other behaviour is identical.

Test Plan:
1. Reset, en=1 for 10 cycles, no other inputs -> pc 0,1,...,9; pc_4=pc+1; pred_taken=0; if_id_clr=1 throughout.
2. stall=1 for 2 cycles while pc=3 -> pc stays 3 for 2 extra cycles, then 4. Assert redirect=1 with redirect_pc=0x40 during stall -> next pc=0x40 and if_id_clr=0 in that cycle only.
3. upd_en, upd_pc=0x08, upd_taken=1, upd_target=0x20, then fetch reaches 0x08 -> pred_taken=1, pred_target=0x20, next pc=0x20. Then two not-taken updates to 0x08 -> ctr=00; fetch 0x08 -> pred_taken=0, next pc=0x09.
4. Aliasing: entry for 0x08 valid; fetch 0x18 (same index, different tag) -> pred_taken=0. Taken update for 0x18 with target 0x30 replaces the entry; 0x08 then misses.
5. redirect_pc=0x3FF (ADDR_W=10) -> pc=0x3FF, pc_4=0x000, next pc=0x000.
6. halt=1 at pc=7 -> halted=1 after the edge; pc stays 7 despite redirect/upd. Drop rst_n mid-cycle -> pc=0 and halted=0 immediately, and the earlier BTB entry no longer hits.
7. Rebuild without BTB_PRED_EN and replay scenario 3 -> pred_taken stays 0 and pc steps sequentially.
